// File: rtl/md_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: operation codes,
// FSM states and default latencies.
package md_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_ctrl_arith.sv
// Combinational multiply/divide datapath working on the latched operands.
// Produces the 64-bit {HI,LO} result and a divide-by-zero flag.
module md_ctrl_arith
  import md_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  md_op_e           op_i,
  output logic [WIDTH-1:0] hi_res_o,
  output logic [WIDTH-1:0] lo_res_o,
  output logic             div_by_zero_o
);

  logic signed [2*WIDTH-1:0] smul;
  logic        [2*WIDTH-1:0] umul;
  logic                      b_zero;
  logic                      div_ovf;
  logic        [WIDTH-1:0]   b_safe;
  logic signed [WIDTH-1:0]   sq;
  logic signed [WIDTH-1:0]   sr;
  logic        [WIDTH-1:0]   uq;
  logic        [WIDTH-1:0]   ur;

  assign smul = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
  assign umul = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

  // Dividing by 1 yields exactly the required MIN/-1 answer (quotient = A,
  // remainder = 0) and keeps zero divisors away from the divider.
  assign b_zero  = (b_i == '0);
  assign div_ovf = (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);
  assign b_safe  = (b_zero || (div_ovf && op_i == MD_DIV)) ? WIDTH'(1) : b_i;

  assign sq = $signed(a_i) / $signed(b_safe);
  assign sr = $signed(a_i) % $signed(b_safe);
  assign uq = a_i / b_safe;
  assign ur = a_i % b_safe;

  assign div_by_zero_o = op_i[1] && b_zero;

  always_comb begin
    hi_res_o = '0;
    lo_res_o = '0;
    case (op_i)
      MD_MULT:  {hi_res_o, lo_res_o} = smul;
      MD_MULTU: {hi_res_o, lo_res_o} = umul;
      MD_DIV: begin
        hi_res_o = sr;
        lo_res_o = sq;
      end
      MD_DIVU: begin
        hi_res_o = ur;
        lo_res_o = uq;
      end
      default: begin
        hi_res_o = '0;
        lo_res_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer with the HI/LO register pair beside the EX-stage ALU.
// Counts a fixed latency, commits to HI/LO, serves mfhi/mflo/mthi/mtlo and stalls D.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic             rd_sel,
  input  logic             md_use_D,
  output logic             busy,
  output logic             stall_md,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] md_out
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  md_op_e           op_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH-1:0] hi_res;
  logic [WIDTH-1:0] lo_res;
  logic             div_by_zero;

  md_ctrl_arith #(
    .WIDTH (WIDTH)
  ) u_arith (
    .a_i           (a_q),
    .b_i           (b_q),
    .op_i          (op_q),
    .hi_res_o      (hi_res),
    .lo_res_o      (lo_res),
    .div_by_zero_o (div_by_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MD_MULT;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // start has priority over a same-cycle mthi/mtlo.
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= md_op_e'(md_op);
            cnt_q   <= md_op[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
            state_q <= ST_BUSY;
          end else begin
            if (wr_hi) hi_q <= A;
            if (wr_lo) lo_q <= A;
          end
        end
        ST_BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            if (!div_by_zero) begin
              hi_q <= hi_res;
              lo_q <= lo_res;
            end
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state_q == ST_BUSY);
  assign stall_md = md_use_D & (start | busy);
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign md_out   = rd_sel ? hi_q : lo_q;

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multiply/divide sequencer with HI/LO register pair, attached beside the EX-stage ALU of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu from EX using forwarded RS/RT operands and counts a fixed latency before committing results to HI/LO.
- Serves mfhi/mflo reads and mthi/mtlo writes.
- Generates the D-stage stall request so that no HI/LO-dependent instruction enters EX while the unit is busy.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  EX holds mult/multu/div/divu this cycle.
- md_op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; valid with start.
- A  in  WIDTH  forwarded RS operand from EX.
- B  in  WIDTH  forwarded RT operand from EX.
- wr_hi  in  1  mthi in EX; A is the write data.
- wr_lo  in  1  mtlo in EX; A is the write data.
- rd_sel  in  1  0=read LO, 1=read HI (mflo/mfhi in EX).
- md_use_D  in  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo.
- busy  out  1  operation in progress.
- stall_md  out  1  stall request to the hazard unit.
- HI  out  WIDTH  architectural HI.
- LO  out  WIDTH  architectural LO.
- md_out  out  WIDTH  rd_sel ? HI : LO, combinational.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, HI=0, LO=0, cnt=0, busy=0, operand latches=0. Reset mid-operation aborts the operation: no HI/LO update, IDLE on the next cycle.
- FSM has two states, IDLE and BUSY.
- IDLE with start=1 at edge:
  - Latch A, B, md_op.
  - cnt <= (md_op[1] ? DIV_CYCLES : MULT_CYCLES) - 1.
  - Go to BUSY.
- BUSY, cnt!=0: cnt decrements by 1 each edge.
- BUSY, cnt==0 at edge:
  - Commit result to HI/LO; return to IDLE.
  - busy is therefore high for exactly N cycles (5 or 10), starting the cycle after start. New HI/LO is visible the cycle busy falls.
- busy = (state==BUSY).
- Results are computed from the latched operands:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - DIV with 0x80000000 / -1: LO=0x80000000, HI=0.
- Divisor zero (DIV/DIVU): full latency is still spent; HI and LO are left unchanged at commit.
- mthi/mtlo:
  - In IDLE with wr_hi/wr_lo and no start: HI<=A or LO<=A at the edge. wr_hi and wr_lo together write both.
  - While BUSY: ignored (the stall makes this unreachable; the bench asserts it).
- Simultaneous events:
  - start together with wr_* in IDLE: start wins and wr_* is dropped.
  - start while BUSY: ignored.
- stall_md = md_use_D & (start | busy). This is combinational, with no edge delay, so a following mfhi is held in D until the cycle busy falls.
- md_out always reflects the current registered HI/LO. There is no bypass of a commit in the same cycle, and none is needed because of the stall.

Decomposition:
- Shared package holds the md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), the FSM state constants, and the default latencies.
- One natural sub-module: md_arith. It is combinational, takes latched A, B and op, and outputs 64-bit {hi_res, lo_res} plus div_by_zero.
- md_ctrl keeps the FSM, counter, operand latches, HI/LO registers and stall logic.

Test Plan:
- MULT A=0xFFFFFFFE(-2), B=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 with HI=0x11, LO=0x22 beforehand -> HI/LO unchanged after 10 cycles.
- mfhi in D (md_use_D=1) during MULT -> stall_md high the start cycle plus 5 busy cycles, low the cycle busy falls; md_out with rd_sel=1 equals the new HI.
- mthi A=0x1234 in IDLE -> HI=0x1234 next cycle. start+wr_lo in the same cycle -> LO takes the product, not A. start during BUSY -> cnt unchanged.
- Reset asserted at cycle 3 of DIV -> next cycle busy=0, HI=LO=0; a following MULT 6*7 gives LO=42 after 5 cycles.
